data_ram_resp: RTL and testbench

//  Data-memory responder for the open_risc_v load/store port; sits beside the instruction ROM in the SoC.

---
 rtl/data_ram_resp_pkg.sv | 34 +++
 rtl/data_ram_resp_ram_sp_be.sv | 33 +++
 rtl/data_ram_resp.sv | 95 +++++++++
 tb/tb_data_ram_resp.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/data_ram_resp_pkg.sv
// Shared definitions for the data-memory responder: state codes,
// data widths, default base address and address-decode helpers.
package data_ram_resp_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W = 4;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_HOLD = 1'b1
    } rsp_state_t;

    // Word offset from the base; exact because the base is word aligned.
    function automatic logic [29:0] word_off(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return addr[31:2] - base[31:2];
    endfunction

    function automatic logic addr_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] depth
    );
        logic [29:0] w_word;
        w_word = word_off(addr, base);
        return (addr[1:0] != 2'b00)
            || (addr < base)
            || ({2'b00, w_word} >= depth);
    endfunction

endpackage

// File: rtl/data_ram_resp_ram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables
// and a registered read port that holds its value between reads.
module ram_sp_be
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic [BE_W-1:0]   i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: valid/ready request and response channels,
// one-cycle latency, byte-enable writes and misalign/range errors.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int DEPTH_WORDS = 1024,
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    input  logic [BE_W-1:0]   req_be_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WORD_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    rsp_state_t r_state;
    rsp_state_t w_state_nxt;

    logic              w_accept;
    logic              w_err;
    logic [29:0]       w_word;
    logic [BE_W-1:0]   w_ram_we;
    logic              w_ram_re;
    logic [WORD_W-1:0] w_ram_q;
    logic              r_err;
    logic              r_rd_ok;

    assign rsp_valid_o = (r_state == RSP_HOLD);
    assign req_ready_o = !rsp_valid_o || rsp_ready_i;
    assign w_accept = req_valid_i && req_ready_o;

    assign w_word = word_off(req_addr_i, BASE_ADDR);
    assign w_err = addr_err(req_addr_i, BASE_ADDR, 32'(DEPTH_WORDS));

    // Reset on the accept edge suppresses both the write and the read.
    assign w_ram_we = (w_accept && req_we_i && !w_err && !rst)
                    ? req_be_i : '0;
    assign w_ram_re = w_accept && !req_we_i && !w_err && !rst;

    ram_sp_be #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_word[AW-1:0]),
        .i_wdata (req_wdata_i),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RSP_IDLE: begin
                if (w_accept) w_state_nxt = RSP_HOLD;
            end
            RSP_HOLD: begin
                if (rsp_ready_i && !w_accept) w_state_nxt = RSP_IDLE;
            end
            default: w_state_nxt = RSP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RSP_IDLE;
            r_err   <= 1'b0;
            r_rd_ok <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_err   <= w_err;
                r_rd_ok <= !req_we_i && !w_err;
            end else if (rsp_ready_i) begin
                r_err   <= 1'b0;
                r_rd_ok <= 1'b0;
            end
        end
    end

    // The RAM output register only moves on a read accept, so it
    // stays stable for as long as the response is held.
    assign rsp_rdata_o = r_rd_ok ? w_ram_q : '0;
    assign rsp_err_o = r_err;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed self-checking bench for data_ram_resp using
// immediate assertions at each comparison point.
module tb_data_ram_resp;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int checks = 0;
    int errors = 0;

    data_ram_resp dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request at the current negedge; return at the next
    // negedge, by which time its response is on the outputs.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = 32'hxxxx_xxxx;
        req_wdata_i = 32'hxxxx_xxxx;
        req_be_i    = 4'hx;
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] rdata,
                           input logic err);
        chk({tag, ".valid"}, {31'd0, rsp_valid_o}, 32'd1);
        chk({tag, ".rdata"}, rsp_rdata_o, rdata);
        chk({tag, ".err"}, {31'd0, rsp_err_o}, {31'd0, err});
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
        rsp_ready_i = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst.valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst.rdata", rsp_rdata_o, 32'd0);
        chk("rst.err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst.ready", {31'd0, req_ready_o}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        issue(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        chk_rsp("wr1000", 32'd0, 1'b0);
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        chk_rsp("rd1000", 32'hDEAD_BEEF, 1'b0);

        issue(1'b1, 32'h0000_1004, 32'h1122_3344, 4'hF);
        chk_rsp("wr1004", 32'd0, 1'b0);
        issue(1'b1, 32'h0000_1004, 32'hAABB_CCDD, 4'b0101);
        chk_rsp("wr1004be", 32'd0, 1'b0);
        issue(1'b0, 32'h0000_1004, 32'h0, 4'hF);
        chk_rsp("rd1004", 32'h11BB_33DD, 1'b0);

        issue(1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 4'b0000);
        chk_rsp("wrbe0", 32'd0, 1'b0);
        issue(1'b0, 32'h0000_1004, 32'h0, 4'h0);
        chk_rsp("rdbe0", 32'h11BB_33DD, 1'b0);

        issue(1'b0, 32'h0000_1002, 32'h0, 4'h0);
        chk_rsp("rdmis", 32'd0, 1'b1);
        issue(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        chk_rsp("rdhigh", 32'd0, 1'b1);
        issue(1'b0, 32'h0000_0FFC, 32'h0, 4'h0);
        chk_rsp("rdlow", 32'd0, 1'b1);
        issue(1'b1, 32'h0000_1001, 32'h0BAD_0BAD, 4'hF);
        chk_rsp("wrmis", 32'd0, 1'b1);
        issue(1'b1, 32'hFFFF_F000, 32'h0BAD_0BAD, 4'hF);
        chk_rsp("wrwrap", 32'd0, 1'b1);
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        chk_rsp("rdkeep", 32'hDEAD_BEEF, 1'b0);

        issue(1'b1, 32'h0000_1FFC, 32'hCAFE_F00D, 4'hF);
        chk_rsp("wrlast", 32'd0, 1'b0);
        issue(1'b0, 32'h0000_1FFC, 32'h0, 4'h0);
        chk_rsp("rdlast", 32'hCAFE_F00D, 1'b0);

        // Back-pressure: first response held while rsp_ready_i is low.
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h0000_1004;
        #1;
        chk("bp.ready0", {31'd0, req_ready_o}, 32'd0);
        chk_rsp("bp.first", 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_rsp("bp.hold", 32'hDEAD_BEEF, 1'b0);
            chk("bp.hold.ready", {31'd0, req_ready_o}, 32'd0);
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("bp.ready1", {31'd0, req_ready_o}, 32'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        #1;
        chk_rsp("bp.second", 32'h11BB_33DD, 1'b0);

        issue(1'b1, 32'h0000_1008, 32'h0BAD_F00D, 4'hF);
        chk_rsp("wr1008", 32'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("idle.valid", {31'd0, rsp_valid_o}, 32'd0);

        // Reset lands on the accept edge of a write.
        rst = 1'b1;
        issue(1'b1, 32'h0000_1008, 32'h5555_5555, 4'hF);
        rst = 1'b0;
        chk("rstwr.valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rstwr.err", {31'd0, rsp_err_o}, 32'd0);
        chk("rstwr.rdata", rsp_rdata_o, 32'd0);
        issue(1'b0, 32'h0000_1008, 32'h0, 4'h0);
        chk_rsp("rd1008", 32'h0BAD_F00D, 1'b0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
